// File: rtl/wb_pkg.sv
// Shared definitions for the writeback/register-file slice: wb select codes and default widths.
// No logic here; imported by wb_regfile and regfile_2r1w.
// Optional hardwired-zero register 0 is enabled with WB_ZERO_REG_EN.
package wb_pkg;

  localparam int WB_DATA_W = 32;
  localparam int WB_ADDR_W = 4;

  typedef enum logic [1:0] {
    WB_NONE = 2'b00,
    WB_R2   = 2'b01,
    WB_ALU  = 2'b10,
    WB_MEM  = 2'b11
  } wb_sel_t;

endpackage

// File: rtl/regfile_2r1w.sv
// Register array: one synchronous write port, two combinational read ports with write-first bypass.
// Latency: write lands on posedge; reads are same-cycle. No backpressure (always accepts).
// WB_ZERO_REG_EN: register 0 reads as zero and ignores writes.
module regfile_2r1w
  import wb_pkg::*;
#(
  parameter int DATA_W = WB_DATA_W,
  parameter int ADDR_W = WB_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr1_i,
  input  logic [ADDR_W-1:0] raddr2_i,
  output logic [DATA_W-1:0] rdata1_o,
  output logic [DATA_W-1:0] rdata2_o
);

  localparam int NREGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_q [NREGS];
  logic              wr_en;

`ifdef WB_ZERO_REG_EN
  assign wr_en = we_i && (waddr_i != '0);
`else
  assign wr_en = we_i;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_en) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  // Write-first: a same-cycle write to the addressed register wins over storage.
  always_comb begin
    rdata1_o = (wr_en && (waddr_i == raddr1_i)) ? wdata_i : regs_q[raddr1_i];
    rdata2_o = (wr_en && (waddr_i == raddr2_i)) ? wdata_i : regs_q[raddr2_i];
`ifdef WB_ZERO_REG_EN
    if (raddr1_i == '0) rdata1_o = '0;
    if (raddr2_i == '0) rdata2_o = '0;
`endif
  end

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage: wb-code mux, register-file commit, one-cycle-late forwarding record, write counter.
// Latency: reads bypass same cycle; fwd_* and wr_count update one posedge after commit. No backpressure.
// WB_ZERO_REG_EN: writes to register 0 are discarded (not forwarded, not counted).
module wb_regfile
  import wb_pkg::*;
#(
  parameter int DATA_W = WB_DATA_W,
  parameter int ADDR_W = WB_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        wb,
  input  logic [DATA_W-1:0] r2,
  input  logic [DATA_W-1:0] resALU,
  input  logic [DATA_W-1:0] memData,
  input  logic [ADDR_W-1:0] dest,
  input  logic [ADDR_W-1:0] rs1_addr,
  input  logic [ADDR_W-1:0] rs2_addr,
  output logic [DATA_W-1:0] rs1_data,
  output logic [DATA_W-1:0] rs2_data,
  output logic              fwd_valid,
  output logic [ADDR_W-1:0] fwd_dest,
  output logic [DATA_W-1:0] fwd_data,
  output logic [31:0]       wr_count
);

  wb_sel_t           wb_sel;
  logic [DATA_W-1:0] wdata;
  logic              zero_block;
  logic              we;

  logic              fwd_valid_q, fwd_valid_d;
  logic [ADDR_W-1:0] fwd_dest_q,  fwd_dest_d;
  logic [DATA_W-1:0] fwd_data_q,  fwd_data_d;
  logic [31:0]       wr_count_q,  wr_count_d;

  assign wb_sel = wb_sel_t'(wb);

  always_comb begin
    wdata = '0;
    case (wb_sel)
      WB_R2:   wdata = r2;
      WB_ALU:  wdata = resALU;
      WB_MEM:  wdata = memData;
      default: wdata = '0;
    endcase
  end

`ifdef WB_ZERO_REG_EN
  assign zero_block = (dest == '0);
`else
  assign zero_block = 1'b0;
`endif

  // A write coinciding with reset is dropped entirely, including from the bypass path.
  assign we = (wb_sel != WB_NONE) && !rst && !zero_block;

  regfile_2r1w #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_rf (
    .clk      (clk),
    .rst      (rst),
    .we_i     (we),
    .waddr_i  (dest),
    .wdata_i  (wdata),
    .raddr1_i (rs1_addr),
    .raddr2_i (rs2_addr),
    .rdata1_o (rs1_data),
    .rdata2_o (rs2_data)
  );

  always_comb begin
    fwd_valid_d = 1'b0;
    fwd_dest_d  = fwd_dest_q;
    fwd_data_d  = fwd_data_q;
    wr_count_d  = wr_count_q;
    if (we) begin
      fwd_valid_d = 1'b1;
      fwd_dest_d  = dest;
      fwd_data_d  = wdata;
      wr_count_d  = wr_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fwd_valid_q <= 1'b0;
      fwd_dest_q  <= '0;
      fwd_data_q  <= '0;
      wr_count_q  <= '0;
    end else begin
      fwd_valid_q <= fwd_valid_d;
      fwd_dest_q  <= fwd_dest_d;
      fwd_data_q  <= fwd_data_d;
      wr_count_q  <= wr_count_d;
    end
  end

  assign fwd_valid = fwd_valid_q;
  assign fwd_dest  = fwd_dest_q;
  assign fwd_data  = fwd_data_q;
  assign wr_count  = wr_count_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Bench for wb_regfile: directed steps plus random traffic against a behavioural register-file model.
// Inputs change on negedge; reads sampled #1 later, registered outputs sampled #1 after posedge.
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  wb;
  logic [31:0] r2, resALU, memData;
  logic [3:0]  dest, rs1_addr, rs2_addr;
  logic [31:0] rs1_data, rs2_data, fwd_data, wr_count;
  logic        fwd_valid;
  logic [3:0]  fwd_dest;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_regs [16];
  logic        m_fwd_valid;
  logic [3:0]  m_fwd_dest;
  logic [31:0] m_fwd_data;
  logic [31:0] m_count;

  always #5 clk = ~clk;

  wb_regfile dut (
    .clk       (clk),
    .rst       (rst),
    .wb        (wb),
    .r2        (r2),
    .resALU    (resALU),
    .memData   (memData),
    .dest      (dest),
    .rs1_addr  (rs1_addr),
    .rs2_addr  (rs2_addr),
    .rs1_data  (rs1_data),
    .rs2_data  (rs2_data),
    .fwd_valid (fwd_valid),
    .fwd_dest  (fwd_dest),
    .fwd_data  (fwd_data),
    .wr_count  (wr_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] wsel(input logic [1:0] w, input logic [31:0] a, b, c);
    return (w == 2'd1) ? a : (w == 2'd2) ? b : (w == 2'd3) ? c : 32'd0;
  endfunction

  function automatic bit m_we();
    bit blocked = 1'b0;
`ifdef WB_ZERO_REG_EN
    blocked = (dest == 4'd0);
`endif
    return (wb != 2'd0) && !rst && !blocked;
  endfunction

  function automatic logic [31:0] m_read(input logic [3:0] a);
`ifdef WB_ZERO_REG_EN
    if (a == 4'd0) return 32'd0;
`endif
    if (m_we() && dest == a) return wsel(wb, r2, resALU, memData);
    return m_regs[a];
  endfunction

  // One cycle: drive on negedge, check reads, commit in model at posedge, check registered outputs.
  task automatic step(input logic r, input logic [1:0] w, input logic [3:0] d,
                      input logic [31:0] v2, va, vm, input logic [3:0] a1, a2);
    bit we_now;
    logic [31:0] wd;
    @(negedge clk);
    rst = r; wb = w; dest = d; r2 = v2; resALU = va; memData = vm;
    rs1_addr = a1; rs2_addr = a2;
    #1;
    chk("rs1_data", rs1_data, m_read(a1));
    chk("rs2_data", rs2_data, m_read(a2));
    we_now = m_we();
    wd = wsel(w, v2, va, vm);
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < 16; i++) m_regs[i] = 32'd0;
      m_fwd_valid = 1'b0; m_fwd_dest = 4'd0; m_fwd_data = 32'd0; m_count = 32'd0;
    end else if (we_now) begin
      m_regs[d] = wd;
      m_fwd_valid = 1'b1; m_fwd_dest = d; m_fwd_data = wd; m_count = m_count + 32'd1;
    end else begin
      m_fwd_valid = 1'b0;
    end
    #1;
    chk("fwd_valid", {31'd0, fwd_valid}, {31'd0, m_fwd_valid});
    chk("fwd_dest", {28'd0, fwd_dest}, {28'd0, m_fwd_dest});
    chk("fwd_data", fwd_data, m_fwd_data);
    chk("wr_count", wr_count, m_count);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; wb = 2'd0; dest = 4'd0; r2 = '0; resALU = '0; memData = '0;
    rs1_addr = 4'd0; rs2_addr = 4'd0;
    for (int i = 0; i < 16; i++) m_regs[i] = 32'd0;
    m_fwd_valid = 1'b0; m_fwd_dest = 4'd0; m_fwd_data = 32'd0; m_count = 32'd0;
    repeat (2) @(posedge clk);

    // Reset state: all 16 registers read zero on both ports.
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 2'd0, 4'd0, 32'd0, 32'd0, 32'd0, 4'(i), 4'(15 - i));
      chk("reset_rs1", rs1_data, 32'd0);
    end
    chk("reset_fwd_valid", {31'd0, fwd_valid}, 32'd0);
    chk("reset_wr_count", wr_count, 32'd0);

    // ALU write with same-cycle bypass.
    step(1'b0, 2'b10, 4'd5, 32'd0, 32'hDEADBEEF, 32'd0, 4'd5, 4'd5);
    chk("alu_fwd_valid", {31'd0, fwd_valid}, 32'd1);
    chk("alu_fwd_dest", {28'd0, fwd_dest}, 32'd5);
    chk("alu_fwd_data", fwd_data, 32'hDEADBEEF);
    chk("alu_wr_count", wr_count, 32'd1);
    chk("alu_stored", rs1_data, 32'hDEADBEEF);

    // Back-to-back writes to the same register after a reset.
    step(1'b1, 2'd0, 4'd0, 32'd0, 32'd0, 32'd0, 4'd3, 4'd3);
    step(1'b0, 2'b11, 4'd3, 32'd0, 32'd0, 32'h1234, 4'd3, 4'd3);
    chk("b2b_fwd1", {31'd0, fwd_valid}, 32'd1);
    step(1'b0, 2'b01, 4'd3, 32'h5678, 32'd0, 32'd0, 4'd3, 4'd3);
    chk("b2b_fwd2", {31'd0, fwd_valid}, 32'd1);
    chk("b2b_fwd_data", fwd_data, 32'h5678);
    step(1'b0, 2'b00, 4'd3, 32'd0, 32'd0, 32'd0, 4'd1, 4'd3);
    chk("b2b_rs2", rs2_data, 32'h5678);
    chk("b2b_count", wr_count, 32'd2);
    chk("b2b_fwd_low", {31'd0, fwd_valid}, 32'd0);

    // No-write code leaves register 7 and the counter alone.
    step(1'b0, 2'b00, 4'd7, 32'h77, 32'h77, 32'h77, 4'd7, 4'd7);
    chk("nowr_reg7", rs1_data, 32'd0);
    chk("nowr_count", wr_count, 32'd2);

    // Random traffic with occasional reset.
    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(0, 39) == 0), 2'($urandom), 4'($urandom),
           $urandom, $urandom, $urandom, 4'($urandom), 4'($urandom));
    end

    // Write presented with reset is dropped.
    step(1'b0, 2'b10, 4'd9, 32'd0, 32'h1111, 32'd0, 4'd9, 4'd9);
    step(1'b1, 2'b10, 4'd9, 32'd0, 32'hFFFF, 32'd0, 4'd9, 4'd9);
    step(1'b0, 2'b00, 4'd9, 32'd0, 32'd0, 32'd0, 4'd9, 4'd9);
    chk("rstwr_reg9", rs1_data, 32'd0);
    chk("rstwr_count", wr_count, 32'd0);

    // Counter wraps from all-ones to zero.
    @(negedge clk);
    force dut.wr_count_q = 32'hFFFFFFFF;
    @(posedge clk);
    @(negedge clk);
    release dut.wr_count_q;
    m_count = 32'hFFFFFFFF;
    #1;
    chk("wrap_preload", wr_count, 32'hFFFFFFFF);
    step(1'b0, 2'b01, 4'd2, 32'hABCD, 32'd0, 32'd0, 4'd2, 4'd0);
    chk("wrap_count", wr_count, 32'd0);

`ifdef WB_ZERO_REG_EN
    step(1'b0, 2'b01, 4'd0, 32'hAA, 32'd0, 32'd0, 4'd0, 4'd0);
    chk("zero_fwd_valid", {31'd0, fwd_valid}, 32'd0);
    chk("zero_rs1", rs1_data, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
